// File: rtl/rf_pkg.sv
// Shared constants and types for the RV32I integer register file.
package rf_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file; index 0 always reads zero.
module rf_read_port
    import rf_pkg::*;
(
    input  xlen_t [NUM_REGS-1:1] regs,
    input  reg_addr_t            sel,
    output xlen_t                data
);

    // x0 has no storage behind it, so it is masked to zero here
    always_comb begin
        data = {XLEN{1'b0}};
        if (sel == ZERO_REG) begin
            data = {XLEN{1'b0}};
        end else begin
            data = regs[sel];
        end
    end

endmodule

// File: rtl/rf.sv
// 32 x 32 register file: two combinational read ports, one synchronous write port.
module rf
    import rf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  reg_s1,
    input  logic [4:0]  reg_s2,
    input  logic [4:0]  rd,
    input  logic        write_e,
    input  logic [31:0] write_d,
    output logic [31:0] reg_d1,
    output logic [31:0] reg_d2
);

    xlen_t [NUM_REGS-1:1] regs_r;

    // Storage for x1..x31; reset wins over a simultaneous write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (write_e && (rd != ZERO_REG)) begin
            regs_r[rd] <= write_d;
        end
    end

    rf_read_port u_port1 (
        .regs (regs_r),
        .sel  (reg_s1),
        .data (reg_d1)
    );

    rf_read_port u_port2 (
        .regs (regs_r),
        .sel  (reg_s2),
        .data (reg_d2)
    );

endmodule

// File: tb/tb_rf.sv
// Directed self-checking bench for the register file.
module tb_rf;

    logic        clk;
    logic        rst;
    logic [4:0]  reg_s1;
    logic [4:0]  reg_s2;
    logic [4:0]  rd;
    logic        write_e;
    logic [31:0] write_d;
    logic [31:0] reg_d1;
    logic [31:0] reg_d2;

    int n_pass;
    int n_total;

    rf dut (
        .clk     (clk),
        .rst     (rst),
        .reg_s1  (reg_s1),
        .reg_s2  (reg_s2),
        .rd      (rd),
        .write_e (write_e),
        .write_d (write_d),
        .reg_d1  (reg_d1),
        .reg_d2  (reg_d2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd2(input logic [4:0] a1, input logic [4:0] a2);
        reg_s1 = a1;
        reg_s2 = a2;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rd      = a;
        write_d = d;
        write_e = 1'b1;
        tick();
        write_e = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        reg_s1  = 5'd0;
        reg_s2  = 5'd0;
        rd      = 5'd0;
        write_e = 1'b0;
        write_d = 32'd0;
        #2;
        tick();
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rd2(5'(i), 5'(31 - i));
            chk("reset_p1", reg_d1, 32'd0);
            chk("reset_p2", reg_d2, 32'd0);
        end

        wr(5'd4, 32'd42);
        rd2(5'd4, 5'd0);
        chk("x4_p1", reg_d1, 32'd42);
        chk("x0_p2", reg_d2, 32'd0);

        wr(5'd2, 32'd99);
        rd2(5'd2, 5'd4);
        chk("x2_p1", reg_d1, 32'd99);
        chk("x4_kept_p2", reg_d2, 32'd42);

        wr(5'd0, 32'hDEADBEEF);
        rd2(5'd0, 5'd0);
        chk("x0_wr_p1", reg_d1, 32'd0);
        chk("x0_wr_p2", reg_d2, 32'd0);
        rd2(5'd2, 5'd4);
        chk("x0_wr_x2", reg_d1, 32'd99);
        chk("x0_wr_x4", reg_d2, 32'd42);

        rd      = 5'd7;
        write_d = 32'h1234;
        write_e = 1'b0;
        tick();
        rd2(5'd7, 5'd7);
        chk("noen_x7_p1", reg_d1, 32'd0);
        chk("noen_x7_p2", reg_d2, 32'd0);

        rd2(5'd4, 5'd4);
        rd      = 5'd4;
        write_d = 32'h55;
        write_e = 1'b1;
        #1;
        chk("rdw_before_p1", reg_d1, 32'd42);
        chk("rdw_before_p2", reg_d2, 32'd42);
        tick();
        write_e = 1'b0;
        chk("rdw_after_p1", reg_d1, 32'h55);
        chk("rdw_after_p2", reg_d2, 32'h55);

        rst     = 1'b1;
        rd      = 5'd4;
        write_d = 32'h77;
        write_e = 1'b1;
        tick();
        rst     = 1'b0;
        write_e = 1'b0;
        rd2(5'd4, 5'd2);
        chk("rst_prio_x4", reg_d1, 32'd0);
        chk("rst_x2", reg_d2, 32'd0);

        wr(5'd1, 32'h0000_0011);
        wr(5'd31, 32'hCAFE_0031);
        wr(5'd15, 32'hA5A5_5A5A);
        rd2(5'd1, 5'd31);
        chk("x1", reg_d1, 32'h0000_0011);
        chk("x31", reg_d2, 32'hCAFE_0031);
        rd2(5'd15, 5'd16);
        chk("x15", reg_d1, 32'hA5A5_5A5A);
        chk("x16_untouched", reg_d2, 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd2(5'(i), 5'(31 - i));
            chk("rst2_p1", reg_d1, 32'd0);
            chk("rst2_p2", reg_d2, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
